rr_fifo_arbiter: RTL and testbench

Parametrised multi-channel buffered arbiter: CH independent FIFOs of DEPTH × WIDTH entries feed one registered output port under round-robin arbitration. It succeeds the fixed 4×8-bit arbiter with a downstream ready handshake, per-channel full/overflow reporting and work-conserving grant selection that skips empty channels. It sits between multiple byte/word producers and a single consumer.

---
 rtl/rr_fifo_arbiter_if.sv | 27 ++
 rtl/rr_fifo_arbiter.sv | 152 +++++++++++++++
 tb/tb_rr_fifo_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_fifo_arbiter_if.sv
// Producer/consumer bus of rr_fifo_arbiter: per-channel write side plus the
// single registered output port with its ready handshake.
interface rr_fifo_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int CH    = 4
);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  logic [CH-1:0]       wen;
  logic [CH*WIDTH-1:0] din;
  logic                out_ready;
  logic [WIDTH-1:0]    dout;
  logic                valid;
  logic [CW-1:0]       ch;
  logic [CH-1:0]       full;
  logic [CH-1:0]       ovf;

  modport master (
    output wen, din, out_ready,
    input  dout, valid, ch, full, ovf
  );

  modport slave (
    input  wen, din, out_ready,
    output dout, valid, ch, full, ovf
  );
endinterface

// File: rtl/rr_fifo_arbiter.sv
// CH per-channel FIFOs drained round-robin into one registered output port.
// Define RR_ARB_STRICT_SLOT_EN for fixed time-slot grants (bubbles on empty slots).
module rr_fifo_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CH    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  rr_fifo_arbiter_if.slave bus
);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam logic [NW-1:0] DEPTH_N  = NW'(DEPTH);
  localparam logic [CW-1:0] LAST_RST = CW'(CH - 1);

  logic [WIDTH-1:0] mem_r    [CH][DEPTH];
  logic [AW-1:0]    wr_ptr_r [CH];
  logic [AW-1:0]    rd_ptr_r [CH];
  logic [NW-1:0]    count_r  [CH];

  logic [WIDTH-1:0] dout_r;
  logic             valid_r;
  logic [CW-1:0]    ch_r;
  logic [CW-1:0]    last_r;
  logic [CH-1:0]    ovf_r;

  logic             load_s;
  logic             gnt_hit_s;
  logic [CW-1:0]    gnt_id_s;
  logic [CW-1:0]    slot_id_s;
  logic [WIDTH-1:0] head_s;
  logic [CH-1:0]    nonempty_s;
  logic [CH-1:0]    full_s;
  logic [CH-1:0]    pop_s;
  logic [CH-1:0]    push_s;
  logic [CH-1:0]    drop_s;

  function automatic logic [CW-1:0] next_id(input logic [CW-1:0] base, input int step);
    int sum_v;
    sum_v = int'(base) + step;
    return CW'(sum_v % CH);
  endfunction

  // Occupancy flags from registered counts only; a same-cycle pop is not reflected.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      nonempty_s[i] = (count_r[i] != {NW{1'b0}});
      full_s[i]     = (count_r[i] == DEPTH_N);
    end
  end

  // Grant selection for the next output load.
  always_comb begin
    load_s    = !valid_r || bus.out_ready;
    slot_id_s = next_id(last_r, 1);
`ifdef RR_ARB_STRICT_SLOT_EN
    gnt_id_s  = slot_id_s;
    gnt_hit_s = nonempty_s[slot_id_s];
`else
    gnt_id_s  = slot_id_s;
    gnt_hit_s = 1'b0;
    // Scan farthest-first so the nearest non-empty channel after last wins.
    for (int k = CH; k > 0; k--) begin
      if (nonempty_s[next_id(last_r, k)]) begin
        gnt_id_s  = next_id(last_r, k);
        gnt_hit_s = 1'b1;
      end else begin
        gnt_hit_s = gnt_hit_s;
      end
    end
`endif
    head_s = mem_r[gnt_id_s][rd_ptr_r[gnt_id_s]];
  end

  // Per-channel pop/push/drop decisions; a pop frees a slot for a same-cycle push.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      pop_s[i]  = load_s && gnt_hit_s && (gnt_id_s == CW'(i));
      push_s[i] = bus.wen[i] && (!full_s[i] || pop_s[i]);
      drop_s[i] = bus.wen[i] && !push_s[i];
    end
  end

  // Channel storage; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CH; i++) begin
      if (push_s[i]) begin
        mem_r[i][wr_ptr_r[i]] <= bus.din[i*WIDTH +: WIDTH];
      end
    end
  end

  // Per-channel pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        wr_ptr_r[i] <= {AW{1'b0}};
        rd_ptr_r[i] <= {AW{1'b0}};
        count_r[i]  <= {NW{1'b0}};
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (push_s[i]) begin
          wr_ptr_r[i] <= wr_ptr_r[i] + AW'(1);
        end
        if (pop_s[i]) begin
          rd_ptr_r[i] <= rd_ptr_r[i] + AW'(1);
        end
        case ({push_s[i], pop_s[i]})
          2'b10:   count_r[i] <= count_r[i] + NW'(1);
          2'b01:   count_r[i] <= count_r[i] - NW'(1);
          default: count_r[i] <= count_r[i];
        endcase
      end
    end
  end

  // Output register, round-robin pointer and overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r  <= {WIDTH{1'b0}};
      valid_r <= 1'b0;
      ch_r    <= {CW{1'b0}};
      last_r  <= LAST_RST;
      ovf_r   <= {CH{1'b0}};
    end else begin
      ovf_r <= drop_s;
      if (load_s) begin
        if (gnt_hit_s) begin
          dout_r  <= head_s;
          ch_r    <= gnt_id_s;
          valid_r <= 1'b1;
          last_r  <= gnt_id_s;
        end else begin
          valid_r <= 1'b0;
`ifdef RR_ARB_STRICT_SLOT_EN
          last_r  <= slot_id_s;
`endif
        end
      end
    end
  end

  assign bus.dout  = dout_r;
  assign bus.valid = valid_r;
  assign bus.ch    = ch_r;
  assign bus.full  = full_s;
  assign bus.ovf   = ovf_r;

endmodule

// File: tb/tb_rr_fifo_arbiter.sv
// Bench for rr_fifo_arbiter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rr_fifo_arbiter;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CH    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rr_fifo_arbiter_if #(.WIDTH(WIDTH), .CH(CH)) bus ();

  rr_fifo_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CH(CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  typedef logic [WIDTH-1:0] q_t [$];
  q_t               mq [CH];
  bit               m_valid;
  logic [WIDTH-1:0] m_dout;
  int               m_ch;
  int               m_last;
  logic [CH-1:0]    m_ovf;

  logic [7:0] fair_d [8] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h11, 8'h21, 8'h31, 8'h41};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) mq[i].delete();
    m_valid = 1'b0;
    m_dout  = '0;
    m_ch    = 0;
    m_last  = CH - 1;
    m_ovf   = '0;
  endtask

  task automatic model_step();
    int g;
    g     = -1;
    m_ovf = '0;
    if (!m_valid || bus.out_ready) begin
`ifdef RR_ARB_STRICT_SLOT_EN
      m_last = (m_last + 1) % CH;
      if (mq[m_last].size() > 0) g = m_last;
`else
      for (int k = 1; k <= CH; k++) begin
        if (g < 0 && mq[(m_last + k) % CH].size() > 0) g = (m_last + k) % CH;
      end
`endif
      if (g >= 0) begin
        m_dout  = mq[g].pop_front();
        m_ch    = g;
        m_last  = g;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    // Pop already applied above, so a freed slot is visible to the write.
    for (int i = 0; i < CH; i++) begin
      if (bus.wen[i]) begin
        if (mq[i].size() < DEPTH) mq[i].push_back(bus.din[i*WIDTH +: WIDTH]);
        else m_ovf[i] = 1'b1;
      end
    end
  endtask

  task automatic compare_model();
    logic [CH-1:0] mfull;
    for (int i = 0; i < CH; i++) mfull[i] = (mq[i].size() == DEPTH);
    chk("valid", 32'(bus.valid), 32'(m_valid));
    if (m_valid) begin
      chk("dout", 32'(bus.dout), 32'(m_dout));
      chk("ch", 32'(bus.ch), 32'(m_ch));
    end
    chk("full", 32'(bus.full), 32'(mfull));
    chk("ovf", 32'(bus.ovf), 32'(m_ovf));
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && rst_n) compare_model();
    end
  end

  initial begin
    bus.wen       = '0;
    bus.din       = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset / idle
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_valid", 32'(bus.valid), 32'd0);
      chk("idle_dout", 32'(bus.dout), 32'd0);
      chk("idle_ch", 32'(bus.ch), 32'd0);
      chk("idle_ovf", 32'(bus.ovf), 32'd0);
      chk("idle_full", 32'(bus.full), 32'd0);
    end

    // Round-robin fairness: two words per channel
    bus.din = {8'h40, 8'h30, 8'h20, 8'h10};
    bus.wen = 4'hF;
    @(negedge clk);
    bus.din = {8'h41, 8'h31, 8'h21, 8'h11};
    @(negedge clk);
    bus.wen = '0;
    @(negedge clk);
    for (int j = 0; j < 8; j++) begin
`ifndef RR_ARB_STRICT_SLOT_EN
      chk("fair_dout", 32'(bus.dout), 32'(fair_d[j]));
      chk("fair_ch", 32'(bus.ch), 32'(j % 4));
      chk("fair_valid", 32'(bus.valid), 32'd1);
      chk("fair_model", 32'(m_dout), 32'(fair_d[j]));
`endif
      bus.out_ready = 1'b1;
      @(negedge clk);
    end
`ifndef RR_ARB_STRICT_SLOT_EN
    chk("fair_drained", 32'(bus.valid), 32'd0);
`endif

    // Skip empty channels: only ch1 and ch3 loaded
    bus.din = {8'hB3, 8'h00, 8'hA1, 8'h00};
    bus.wen = 4'b1010;
    @(negedge clk);
    bus.wen = '0;
    @(negedge clk);
`ifndef RR_ARB_STRICT_SLOT_EN
    chk("skip_first", 32'({bus.valid, bus.ch, bus.dout}), 32'({1'b1, 2'd1, 8'hA1}));
    @(negedge clk);
    chk("skip_second", 32'({bus.valid, bus.ch, bus.dout}), 32'({1'b1, 2'd3, 8'hB3}));
    @(negedge clk);
    chk("skip_drained", 32'(bus.valid), 32'd0);
`else
    repeat (8) @(negedge clk);
`endif

    // Full / overflow / wrap under backpressure, three rounds
    for (int r = 0; r < 3; r++) begin
      bus.out_ready = 1'b0;
      bus.din = '0;
      bus.din[2*WIDTH +: WIDTH] = 8'h55;
      bus.wen = 4'b0100;
      @(negedge clk);
      bus.wen = '0;
      @(negedge clk);
`ifndef RR_ARB_STRICT_SLOT_EN
      chk("bp_hold", 32'({bus.valid, bus.ch, bus.dout}), 32'({1'b1, 2'd2, 8'h55}));
`endif
      for (int k = 0; k < 9; k++) begin
        bus.din = '0;
        bus.din[WIDTH-1:0] = 8'(r * 16 + k);
        bus.wen = 4'b0001;
        @(negedge clk);
`ifndef RR_ARB_STRICT_SLOT_EN
        chk("ovf_full0", 32'(bus.full[0]), 32'(k >= 7));
        chk("ovf_pulse0", 32'(bus.ovf[0]), 32'(k == 8));
        chk("bp_dout", 32'({bus.ch, bus.dout}), 32'({2'd2, 8'h55}));
`endif
      end
      bus.wen = '0;
      @(negedge clk);
`ifndef RR_ARB_STRICT_SLOT_EN
      chk("ovf_cleared", 32'(bus.ovf[0]), 32'd0);
      chk("full_held", 32'(bus.full[0]), 32'd1);
`endif
      bus.out_ready = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
`ifndef RR_ARB_STRICT_SLOT_EN
        chk("wrap_word", 32'({bus.valid, bus.ch, bus.dout}), 32'({1'b1, 2'd0, 8'(r * 16 + k)}));
`endif
        @(negedge clk);
      end
`ifndef RR_ARB_STRICT_SLOT_EN
      chk("wrap_drained", 32'(bus.valid), 32'd0);
`else
      repeat (8) @(negedge clk);
`endif
    end

    // Async reset mid-stream
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.wen = 4'hF;
      bus.din = (CH*WIDTH)'($urandom) | (CH*WIDTH)'(32'h01010101);
      @(negedge clk);
    end
    bus.wen = '0;
    @(negedge clk);
    chk("stream_valid", 32'(bus.valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.valid), 32'd0);
    chk("arst_dout", 32'(bus.dout), 32'd0);
    chk("arst_ovf", 32'(bus.ovf), 32'd0);
    chk("arst_full", 32'(bus.full), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("arst_no_stale", 32'(bus.valid), 32'd0);
    end

    // Randomized traffic with shifting write density and backpressure
    for (int c = 0; c < 4000; c++) begin
      int mode;
      mode = c / 500;
      bus.wen = (mode % 2 == 1) ? 4'($urandom) : (4'($urandom) & 4'($urandom));
      bus.din = (CH*WIDTH)'($urandom);
      bus.out_ready = (mode % 3 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    bus.wen = '0;
    bus.out_ready = 1'b1;
    repeat (40) @(negedge clk);
    chk("final_drained", 32'(bus.valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
